multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 83 ++++++++
 rtl/multicycle_ctrl_decode.sv | 37 +++
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funcs, states,
// instruction classes, datapath select codes and the ALU/EXT control helper.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP  = 4'd0,
    CLS_ADDU = 4'd1,
    CLS_SUBU = 4'd2,
    CLS_ORI  = 4'd3,
    CLS_LUI  = 4'd4,
    CLS_LW   = 4'd5,
    CLS_SW   = 4'd6,
    CLS_BEQ  = 4'd7,
    CLS_JAL  = 4'd8,
    CLS_JR   = 4'd9,
    CLS_ILL  = 4'd10
  } instr_class_e;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JAL = 2'd2;
  localparam logic [1:0] PC_SEL_REG = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
  } alu_ctrl_t;

  // ALU/EXT setup per class; MEM reuses it so the address stays stable.
  function automatic alu_ctrl_t alu_ctrl(input instr_class_e cls);
    alu_ctrl_t c;
    c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_ADD};
    case (cls)
      CLS_ADDU:       c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_ADD};
      CLS_SUBU:       c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_SUB};
      CLS_ORI:        c = '{alu_src: 1'b1, ext_op: EXT_ZERO, alu_op: ALU_OR};
      CLS_LUI:        c = '{alu_src: 1'b1, ext_op: EXT_LUI,  alu_op: ALU_ADD};
      CLS_LW, CLS_SW: c = '{alu_src: 1'b1, ext_op: EXT_SIGN, alu_op: ALU_ADD};
      CLS_BEQ:        c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_SUB};
      default:        c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_ADD};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: op/func to instruction class and an
// illegal flag for anything outside the supported set.
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_e cls,
  output logic         illegal
);

  // Opcode first, then func for SPECIAL; unknown encodings fall to CLS_ILL.
  always_comb begin
    cls = CLS_ILL;
    case (op)
      OP_SPECIAL: begin
        case (func)
          FN_SLL:  cls = CLS_NOP;
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILL;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILL;
    endcase
  end

  assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// datapath enables and selects, and counts retired instructions.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  instr_class_e      class_r;
  instr_class_e      dec_class_s;
  logic              dec_illegal_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  instr_cnt_r;
  logic              timeout_s;
  logic              retire_s;
  logic              pc_we_s, ir_we_s, reg_we_s, mem_req_s, mem_we_s, illegal_s;
  alu_ctrl_t         alu_s;

  mc_decode u_decode (
    .op      (op),
    .func    (func),
    .cls     (dec_class_s),
    .illegal (dec_illegal_s)
  );

  assign alu_s     = alu_ctrl(class_r);
  assign timeout_s = (MEM_TIMEOUT > 0) && (wait_cnt_r == WAIT_W'(MEM_TIMEOUT));

  // Next-state and datapath controls; beq's pc_we follows zero within EXEC.
  always_comb begin
    state_nxt_s = ST_FETCH;
    retire_s    = 1'b0;
    pc_we_s     = 1'b0;
    ir_we_s     = 1'b0;
    reg_we_s    = 1'b0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    illegal_s   = 1'b0;
    pc_sel      = PC_SEL_PC4;
    reg_dst     = REG_DST_RT;
    wd_sel      = WD_ALU;
    alu_src     = 1'b0;
    ext_op      = EXT_ZERO;
    alu_op      = ALU_ADD;
    case (state_r)
      ST_FETCH: begin
        ir_we_s     = 1'b1;
        pc_we_s     = 1'b1;
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_illegal_s) begin
          illegal_s = 1'b1;
        end else begin
          case (dec_class_s)
            CLS_NOP: retire_s = 1'b1;
            CLS_JAL: begin
              // PC already holds PC+4, which is the link value.
              pc_we_s  = 1'b1;
              pc_sel   = PC_SEL_JAL;
              reg_we_s = 1'b1;
              reg_dst  = REG_DST_RA;
              wd_sel   = WD_PC;
              retire_s = 1'b1;
            end
            CLS_JR: begin
              pc_we_s  = 1'b1;
              pc_sel   = PC_SEL_REG;
              retire_s = 1'b1;
            end
            default: state_nxt_s = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        alu_src = alu_s.alu_src;
        ext_op  = alu_s.ext_op;
        alu_op  = alu_s.alu_op;
        case (class_r)
          CLS_BEQ: begin
            pc_sel   = PC_SEL_BR;
            pc_we_s  = zero;
            retire_s = 1'b1;
          end
          CLS_LW, CLS_SW: state_nxt_s = ST_MEM;
          default:        state_nxt_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        alu_src   = alu_s.alu_src;
        ext_op    = alu_s.ext_op;
        alu_op    = alu_s.alu_op;
        mem_req_s = 1'b1;
        mem_we_s  = (class_r == CLS_SW);
        if (mem_ready) begin
          if (class_r == CLS_LW) begin
            state_nxt_s = ST_WB;
          end else begin
            retire_s = 1'b1;
          end
        end else if (timeout_s) begin
          illegal_s = 1'b1;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_we_s = 1'b1;
        retire_s = 1'b1;
        case (class_r)
          CLS_ADDU, CLS_SUBU: reg_dst = REG_DST_RD;
          CLS_LW:             wd_sel  = WD_DM;
          default:            reg_dst = REG_DST_RT;
        endcase
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // State, latched class and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_FETCH;
      class_r     <= CLS_NOP;
      instr_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_DECODE) begin
        class_r <= dec_class_s;
      end else begin
        class_r <= class_r;
      end
      if (retire_s) begin
        instr_cnt_r <= instr_cnt_r + CNT_W'(1);
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
    end
  end

  // Counts MEM cycles spent waiting; saturates so unlimited mode never wraps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_MEM) && (state_nxt_s == ST_MEM)) begin
      if (&wait_cnt_r) begin
        wait_cnt_r <= wait_cnt_r;
      end else begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
    end else begin
      wait_cnt_r <= '0;
    end
  end

  assign pc_we     = reset_n & pc_we_s;
  assign ir_we     = reset_n & ir_we_s;
  assign reg_we    = reset_n & reg_we_s;
  assign mem_req   = reset_n & mem_req_s;
  assign mem_we    = reset_n & mem_we_s;
  assign illegal   = reset_n & illegal_s;
  assign state     = state_r;
  assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one default instance plus a second with
// a 2-bit counter and MEM_TIMEOUT=4, both driven from the same stimulus.
module tb_multicycle_ctrl;

  logic        clk, reset_n, zero, mem_ready;
  logic [5:0]  op, func;
  logic        pc_we, ir_we, reg_we, alu_src, mem_req, mem_we, illegal;
  logic [1:0]  pc_sel, reg_dst, wd_sel, ext_op;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_cnt;
  logic        t_pc_we, t_ir_we, t_reg_we, t_alu_src, t_mem_req, t_mem_we, t_illegal;
  logic [1:0]  t_pc_sel, t_reg_dst, t_wd_sel, t_ext_op;
  logic [2:0]  t_alu_op, t_state;
  logic [1:0]  t_instr_cnt;

  int          n_pass, n_total;
  int          exp_cnt;
  logic [20:0] obs, exp_v;
  logic [3:0]  t_obs;

  localparam logic [5:0] T_OP [4] = '{6'h00, 6'h00, 6'h0D, 6'h0F};
  localparam logic [5:0] T_FN [4] = '{6'h21, 6'h23, 6'h00, 6'h00};
  localparam logic       T_AS [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [1:0] T_EO [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
  localparam logic [2:0] T_AO [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
  localparam logic [1:0] T_RD [4] = '{2'd1, 2'd1, 2'd0, 2'd0};

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .pc_sel(pc_sel), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .mem_req(mem_req),
    .mem_we(mem_we), .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  multicycle_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_we(t_pc_we), .ir_we(t_ir_we), .pc_sel(t_pc_sel), .reg_we(t_reg_we), .reg_dst(t_reg_dst),
    .wd_sel(t_wd_sel), .alu_src(t_alu_src), .ext_op(t_ext_op), .alu_op(t_alu_op),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .illegal(t_illegal), .state(t_state),
    .instr_cnt(t_instr_cnt)
  );

  assign obs = {pc_we, ir_we, pc_sel, reg_we, reg_dst, wd_sel, alu_src, ext_op, alu_op,
                mem_req, mem_we, illegal, state};
  assign t_obs = {t_illegal, t_state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic pw, input logic iw, input logic [1:0] ps,
      input logic rw, input logic [1:0] rd, input logic [1:0] ws, input logic as,
      input logic [1:0] eo, input logic [2:0] ao, input logic mr, input logic mw,
      input logic il, input logic [2:0] st);
    return {pw, iw, ps, rw, rd, ws, as, eo, ao, mr, mw, il, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) tick();
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0,0,0,3'd0);
    if (obs !== exp_v) $display("FAIL reset_hold: got %h want %h", obs, exp_v); else n_pass++;
    n_total++;
    if (instr_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", instr_cnt); else n_pass++;
    reset_n = 1'b1; #1;
    n_total++; exp_v = mk(1,1,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0,0,0,3'd0);
    if (obs !== exp_v) $display("FAIL first_fetch: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0,0,0,3'd1);
    if (obs !== exp_v) $display("FAIL nop_decode: got %h want %h", obs, exp_v); else n_pass++;
    tick(); exp_cnt = 1;
    n_total++;
    if (instr_cnt !== 32'(exp_cnt) || state !== 3'd0)
      $display("FAIL nop_retire: got cnt %0d st %0d want cnt %0d st 0", instr_cnt, state, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_alu_classes();
    for (int i = 0; i < 4; i++) begin
      op = T_OP[i]; func = T_FN[i];
      tick(); tick();
      n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,T_AS[i],T_EO[i],T_AO[i],0,0,0,3'd2);
      if (obs !== exp_v) $display("FAIL alu_exec[%0d]: got %h want %h", i, obs, exp_v); else n_pass++;
      tick();
      n_total++; exp_v = mk(0,0,2'd0,1,T_RD[i],2'd0,0,2'd0,3'd0,0,0,0,3'd4);
      if (obs !== exp_v) $display("FAIL alu_wb[%0d]: got %h want %h", i, obs, exp_v); else n_pass++;
      tick(); exp_cnt++;
      n_total++;
      if (instr_cnt !== 32'(exp_cnt) || state !== 3'd0)
        $display("FAIL alu_retire[%0d]: got cnt %0d st %0d want cnt %0d st 0", i, instr_cnt, state, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_lw_wait();
    op = 6'h23; func = 6'h00; mem_ready = 1'b1;
    tick(); tick();
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,1,2'd1,3'd0,0,0,0,3'd2);
    if (obs !== exp_v) $display("FAIL lw_exec: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,1,2'd1,3'd0,1,0,0,3'd3);
      if (obs !== exp_v) $display("FAIL lw_mem[%0d]: got %h want %h", i, obs, exp_v); else n_pass++;
      tick();
    end
    mem_ready = 1'b0; #1;
    n_total++; exp_v = mk(0,0,2'd0,1,2'd0,2'd1,0,2'd0,3'd0,0,0,0,3'd4);
    if (obs !== exp_v) $display("FAIL lw_wb: got %h want %h", obs, exp_v); else n_pass++;
    tick(); exp_cnt++;
    n_total++;
    if (instr_cnt !== 32'(exp_cnt) || state !== 3'd0)
      $display("FAIL lw_retire: got cnt %0d st %0d want cnt %0d st 0", instr_cnt, state, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_beq();
    op = 6'h04; func = 6'h00; zero = 1'b0;
    tick(); tick();
    zero = 1'b1; #1;
    n_total++; exp_v = mk(1,0,2'd1,0,2'd0,2'd0,0,2'd0,3'd1,0,0,0,3'd2);
    if (obs !== exp_v) $display("FAIL beq_taken: got %h want %h", obs, exp_v); else n_pass++;
    zero = 1'b0; #1;
    n_total++; exp_v = mk(0,0,2'd1,0,2'd0,2'd0,0,2'd0,3'd1,0,0,0,3'd2);
    if (obs !== exp_v) $display("FAIL beq_mealy: got %h want %h", obs, exp_v); else n_pass++;
    zero = 1'b1;
    tick(); exp_cnt++;
    zero = 1'b0;
    tick(); tick();
    n_total++; exp_v = mk(0,0,2'd1,0,2'd0,2'd0,0,2'd0,3'd1,0,0,0,3'd2);
    if (obs !== exp_v) $display("FAIL beq_not_taken: got %h want %h", obs, exp_v); else n_pass++;
    tick(); exp_cnt++;
    n_total++;
    if (instr_cnt !== 32'(exp_cnt) || state !== 3'd0)
      $display("FAIL beq_retire: got cnt %0d st %0d want cnt %0d st 0", instr_cnt, state, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_jump_illegal();
    op = 6'h03; func = 6'h00;
    tick();
    n_total++; exp_v = mk(1,0,2'd2,1,2'd2,2'd2,0,2'd0,3'd0,0,0,0,3'd1);
    if (obs !== exp_v) $display("FAIL jal_decode: got %h want %h", obs, exp_v); else n_pass++;
    tick(); exp_cnt++;
    op = 6'h00; func = 6'h08;
    tick();
    n_total++; exp_v = mk(1,0,2'd3,0,2'd0,2'd0,0,2'd0,3'd0,0,0,0,3'd1);
    if (obs !== exp_v) $display("FAIL jr_decode: got %h want %h", obs, exp_v); else n_pass++;
    tick(); exp_cnt++;
    op = 6'h3F; func = 6'h00;
    tick();
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0,0,1,3'd1);
    if (obs !== exp_v) $display("FAIL ill_op: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    n_total++; exp_v = mk(1,1,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0,0,0,3'd0);
    if (obs !== exp_v) $display("FAIL ill_pulse_end: got %h want %h", obs, exp_v); else n_pass++;
    op = 6'h00; func = 6'h20;
    tick();
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0,0,1,3'd1);
    if (obs !== exp_v) $display("FAIL ill_func: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    n_total++;
    if (instr_cnt !== 32'(exp_cnt)) $display("FAIL ill_cnt: got %0d want %0d", instr_cnt, exp_cnt);
    else n_pass++;
    n_total++;
    if (t_instr_cnt !== 2'(exp_cnt % 4))
      $display("FAIL cnt_wrap: got %0d want %0d", t_instr_cnt, exp_cnt % 4);
    else n_pass++;
  endtask

  task automatic test_sw_reset();
    op = 6'h2B; func = 6'h00; mem_ready = 1'b0;
    tick(); tick(); tick();
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,1,2'd1,3'd0,1,1,0,3'd3);
    if (obs !== exp_v) $display("FAIL sw_mem: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    reset_n = 1'b0; #1;
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,1,2'd1,3'd0,0,0,0,3'd3);
    if (obs !== exp_v) $display("FAIL sw_reset_comb: got %h want %h", obs, exp_v); else n_pass++;
    tick(); exp_cnt = 0;
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0,0,0,3'd0);
    if (obs !== exp_v || instr_cnt !== 32'd0)
      $display("FAIL sw_reset_edge: got %h cnt %0d want %h cnt 0", obs, instr_cnt, exp_v);
    else n_pass++;
    reset_n = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b1; #1;
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,1,2'd1,3'd0,1,1,0,3'd3);
    if (obs !== exp_v) $display("FAIL sw_ready: got %h want %h", obs, exp_v); else n_pass++;
    tick(); exp_cnt++;
    mem_ready = 1'b0;
    n_total++;
    if (instr_cnt !== 32'(exp_cnt) || state !== 3'd0)
      $display("FAIL sw_retire: got cnt %0d st %0d want cnt %0d st 0", instr_cnt, state, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    op = 6'h2B; func = 6'h00; mem_ready = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (t_obs !== 4'b0011) $display("FAIL to_wait[%0d]: got %b want 0011", i, t_obs); else n_pass++;
      tick();
    end
    n_total++;
    if (t_obs !== 4'b1011) $display("FAIL to_pulse: got %b want 1011", t_obs); else n_pass++;
    tick();
    n_total++;
    if (t_obs !== 4'b0000 || t_instr_cnt !== 2'(exp_cnt % 4))
      $display("FAIL to_abort: got %b cnt %0d want 0000 cnt %0d", t_obs, t_instr_cnt, exp_cnt % 4);
    else n_pass++;
    n_total++; exp_v = mk(0,0,2'd0,0,2'd0,2'd0,1,2'd1,3'd0,1,1,0,3'd3);
    if (obs !== exp_v) $display("FAIL unlimited_wait: got %h want %h", obs, exp_v); else n_pass++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; exp_cnt = 0;
    reset_n = 1'b0; op = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_alu_classes();
    test_lw_wait();
    test_beq();
    test_jump_illegal();
    test_sw_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
